// File: rtl/inst_realigner.sv
// Fetch-side RV32C realigner: turns a stream of 32-bit fetch words into one
// architectural instruction per handshake, stitching 32-bit instructions that straddle words.
module inst_realigner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    output logic        inst_straddle
);

    typedef enum logic [1:0] {
        EMPTY,
        LO,
        HI
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] buf_q;
    logic [31:0] buf_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        start_hi;
    logic        start_hi_next;
    logic        lo_comp;
    logic        hi_comp;

    assign lo_comp = (buf_q[1:0] != 2'b11);
    assign hi_comp = (buf_q[17:16] != 2'b11);

    // During reset every output is forced quiet, including the PC.
    assign inst_pc = reset_n ? pc_q : 32'h0;

    always_comb begin
        fetch_ready     = 1'b0;
        inst_valid      = 1'b0;
        inst_data       = 32'h0;
        inst_compressed = 1'b0;
        inst_straddle   = 1'b0;
        state_next      = state;
        buf_next        = buf_q;
        pc_next         = pc_q;
        start_hi_next   = start_hi;

        if (flush) begin
            state_next    = EMPTY;
            pc_next       = flush_pc & ~32'h1;
            start_hi_next = flush_pc[1];
        end else if (reset_n) begin
            case (state)
                EMPTY: begin
                    fetch_ready = 1'b1;
                    if (fetch_valid) begin
                        buf_next      = fetch_data;
                        state_next    = start_hi ? HI : LO;
                        start_hi_next = 1'b0;
                    end
                end

                LO: begin
                    inst_valid = 1'b1;
                    if (lo_comp) begin
                        inst_data       = {16'h0, buf_q[15:0]};
                        inst_compressed = 1'b1;
                        if (inst_ready) begin
                            pc_next    = pc_q + 32'd2;
                            state_next = HI;
                        end
                    end else begin
                        inst_data   = buf_q;
                        fetch_ready = inst_ready;
                        if (inst_ready) begin
                            pc_next = pc_q + 32'd4;
                            if (fetch_valid) begin
                                buf_next = fetch_data;
                            end else begin
                                state_next = EMPTY;
                            end
                        end
                    end
                end

                // A non-compressed upper half is completed straight from the incoming word.
                HI: begin
                    fetch_ready = inst_ready;
                    if (hi_comp) begin
                        inst_valid      = 1'b1;
                        inst_data       = {16'h0, buf_q[31:16]};
                        inst_compressed = 1'b1;
                        if (inst_ready) begin
                            pc_next = pc_q + 32'd2;
                            if (fetch_valid) begin
                                buf_next   = fetch_data;
                                state_next = LO;
                            end else begin
                                state_next = EMPTY;
                            end
                        end
                    end else if (fetch_valid) begin
                        inst_valid    = 1'b1;
                        inst_data     = {fetch_data[15:0], buf_q[31:16]};
                        inst_straddle = 1'b1;
                        if (inst_ready) begin
                            buf_next = fetch_data;
                            pc_next  = pc_q + 32'd4;
                        end
                    end
                end

                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= EMPTY;
            pc_q     <= RESET_PC & ~32'h1;
            start_hi <= RESET_PC[1];
            buf_q    <= 32'h0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            start_hi <= start_hi_next;
            buf_q    <= buf_next;
        end
    end

endmodule

// File: tb/tb_inst_realigner.sv
// Self-checking bench for inst_realigner: directed scenarios plus randomized traffic
// checked every cycle against a halfword-queue model of the instruction stream.
module tb_inst_realigner;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic        inst_straddle;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    inst_realigner #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .fetch_ready     (fetch_ready),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_compressed (inst_compressed),
        .inst_straddle   (inst_straddle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic        valid;
        logic        fready;
        logic        comp;
        logic        strad;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        comp;
        logic        strad;
    } rec_t;

    // Model: halves fetched but not yet retired, in program order.
    logic [15:0] pq[$];
    logic [31:0] mPc;
    logic        mDropLo;
    logic        fetchTook;
    rec_t        emitted[$];
    logic [31:0] src[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic isComp(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic exp_t computeExpected();
        exp_t e;
        e = '0;
        if (!reset_n || flush) return e;
        if (pq.size() == 0) begin
            e.fready = 1'b1;
        end else if (isComp(pq[0])) begin
            e.valid  = 1'b1;
            e.comp   = 1'b1;
            e.data   = {16'h0, pq[0]};
            e.fready = (pq.size() == 1) ? inst_ready : 1'b0;
        end else if (pq.size() >= 2) begin
            e.valid  = 1'b1;
            e.data   = {pq[1], pq[0]};
            e.fready = inst_ready;
        end else begin
            e.fready = inst_ready;
            if (fetch_valid) begin
                e.valid = 1'b1;
                e.strad = 1'b1;
                e.data  = {fetch_data[15:0], pq[0]};
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = computeExpected();
        fetchTook = 1'b0;
        if (!reset_n) begin
            pq.delete();
            mPc     = RESET_PC;
            mDropLo = RESET_PC[1];
        end else if (flush) begin
            pq.delete();
            mPc     = flush_pc & ~32'h1;
            mDropLo = flush_pc[1];
        end else begin
            if (fetch_valid && e.fready) begin
                fetchTook = 1'b1;
                if (!mDropLo) pq.push_back(fetch_data[15:0]);
                pq.push_back(fetch_data[31:16]);
                mDropLo = 1'b0;
            end
            if (e.valid && inst_ready) begin
                void'(pq.pop_front());
                if (e.comp) begin
                    mPc = mPc + 32'd2;
                end else begin
                    void'(pq.pop_front());
                    mPc = mPc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = computeExpected();
        if (!reset_n) begin
            checkOutput("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
            checkOutput("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
            checkOutput("rst_inst_data", inst_data, 32'h0);
            checkOutput("rst_inst_pc", inst_pc, 32'h0);
            checkOutput("rst_flags", {30'h0, inst_compressed, inst_straddle}, 32'h0);
        end else begin
            checkOutput("inst_valid", {31'h0, inst_valid}, {31'h0, e.valid});
            checkOutput("fetch_ready", {31'h0, fetch_ready}, {31'h0, e.fready});
            checkOutput("inst_data", inst_data, e.data);
            checkOutput("inst_pc", inst_pc, mPc);
            checkOutput("inst_compressed", {31'h0, inst_compressed}, {31'h0, e.comp});
            checkOutput("inst_straddle", {31'h0, inst_straddle}, {31'h0, e.strad});
            if (inst_valid && inst_ready)
                emitted.push_back({inst_data, inst_pc, inst_compressed, inst_straddle});
        end
    end

    task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic ir,
                                 input logic fl, input logic [31:0] fpc);
        fetch_valid = fv;
        fetch_data  = fd;
        inst_ready  = ir;
        flush       = fl;
        flush_pc    = fpc;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset_fetch_ready", {31'h0, fetch_ready}, 32'h1);
        checkOutput("post_reset_inst_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("post_reset_inst_pc", inst_pc, RESET_PC);
    endtask

    task automatic runSource(input int cycles, input int vpct, input int rpct);
        logic fv;
        for (int i = 0; i < cycles; i++) begin
            fv = (src.size() > 0) && ($urandom_range(99) < vpct);
            applyStimulus(fv, (src.size() > 0) ? src[0] : $urandom,
                          $urandom_range(99) < rpct, 1'b0, 32'h0);
            if (fetchTook && src.size() > 0) void'(src.pop_front());
        end
    endtask

    task automatic expectEmit(input string tag, input int idx, input logic [31:0] d,
                              input logic [31:0] pc, input logic strad);
        if (idx < emitted.size()) begin
            checkOutput({tag, "_data"}, emitted[idx].data, d);
            checkOutput({tag, "_pc"}, emitted[idx].pc, pc);
            checkOutput({tag, "_straddle"}, {31'h0, emitted[idx].strad}, {31'h0, strad});
        end else begin
            checkOutput({tag, "_count"}, emitted.size(), idx + 1);
        end
    endtask

    function automatic logic [15:0] randHalf();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        int base;
        int r;
        logic fv;
        logic [31:0] fpc;

        reset_n     = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        inst_ready  = 1'b0;
        applyReset();

        // Aligned 32-bit followed by two compressed halves
        base = emitted.size();
        src.push_back(32'h0041_0113);
        src.push_back(32'h0001_4501);
        runSource(8, 100, 100);
        checkOutput("tp1_count", emitted.size() - base, 3);
        expectEmit("tp1_0", base + 0, 32'h0041_0113, 32'h0, 1'b0);
        expectEmit("tp1_1", base + 1, 32'h0000_4501, 32'h4, 1'b0);
        expectEmit("tp1_2", base + 2, 32'h0000_0001, 32'h6, 1'b0);

        // Straddling instruction with back-to-back words
        applyReset();
        base = emitted.size();
        src.push_back(32'h0113_4505);
        src.push_back(32'h4501_0041);
        runSource(8, 100, 100);
        checkOutput("tp2_count", emitted.size() - base, 3);
        expectEmit("tp2_0", base + 0, 32'h0000_4505, 32'h0, 1'b0);
        expectEmit("tp2_1", base + 1, 32'h0041_0113, 32'h2, 1'b1);
        expectEmit("tp2_2", base + 2, 32'h0000_4501, 32'h6, 1'b0);

        // Straddle with the second word delayed three cycles
        applyReset();
        base = emitted.size();
        applyStimulus(1'b1, 32'h0113_4505, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("tp3_gap_valid", {31'h0, inst_valid}, 32'h0);
            checkOutput("tp3_gap_pc", inst_pc, 32'h2);
        end
        applyStimulus(1'b1, 32'h4501_0041, 1'b1, 1'b0, 32'h0);
        runSource(4, 100, 100);
        checkOutput("tp3_count", emitted.size() - base, 3);
        expectEmit("tp3_1", base + 1, 32'h0041_0113, 32'h2, 1'b1);
        expectEmit("tp3_2", base + 2, 32'h0000_4501, 32'h6, 1'b0);

        // Flush to a halfword-aligned target; word offered during flush must not be taken
        base = emitted.size();
        flush       = 1'b1;
        flush_pc    = 32'h0000_1002;
        fetch_valid = 1'b1;
        fetch_data  = 32'h4505_0001;
        inst_ready  = 1'b1;
        #2;
        checkOutput("tp4_flush_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        src.push_back(32'h4505_0001);
        runSource(6, 100, 100);
        checkOutput("tp4_count", emitted.size() - base, 1);
        expectEmit("tp4_0", base + 0, 32'h0000_4505, 32'h0000_1002, 1'b0);

        // Back-pressure on a 32-bit instruction in the low slot
        applyReset();
        base = emitted.size();
        applyStimulus(1'b1, 32'h0041_0113, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0001_4501, 1'b0, 1'b0, 32'h0);
            checkOutput("tp5_stall_fetch_ready", {31'h0, fetch_ready}, 32'h0);
            checkOutput("tp5_stall_data", inst_data, 32'h0041_0113);
            checkOutput("tp5_stall_pc", inst_pc, 32'h0);
        end
        applyStimulus(1'b1, 32'h0001_4501, 1'b1, 1'b0, 32'h0);
        checkOutput("tp5_next_data", inst_data, 32'h0000_4501);
        checkOutput("tp5_next_pc", inst_pc, 32'h4);
        runSource(4, 100, 100);
        checkOutput("tp5_count", emitted.size() - base, 3);

        // Reset while waiting for a straddle tail
        applyReset();
        applyStimulus(1'b1, 32'h0113_4505, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("tp6_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("tp6_pc", inst_pc, RESET_PC);
        base = emitted.size();
        src.push_back(32'h0001_4501);
        runSource(6, 100, 100);
        checkOutput("tp6_count", emitted.size() - base, 2);
        expectEmit("tp6_0", base + 0, 32'h0000_4501, 32'h0, 1'b0);
        expectEmit("tp6_1", base + 1, 32'h0000_0001, 32'h2, 1'b0);

        // Randomized traffic with occasional flushes and resets
        src.delete();
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 2) src.push_back({randHalf(), randHalf()});
            r = $urandom_range(199);
            if (r < 2) begin
                reset_n = 1'b0;
                applyStimulus(1'b0, src[0], 1'b0, 1'b0, 32'h0);
                reset_n = 1'b1;
            end else if (r < 6) begin
                fpc = ($urandom_range(1) == 1) ? $urandom
                                               : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
                applyStimulus(1'($urandom_range(1)), src[0], 1'($urandom_range(1)), 1'b1, fpc);
            end else begin
                fv = ($urandom_range(99) < 75);
                applyStimulus(fv, src[0], $urandom_range(99) < 70, 1'b0, 32'h0);
            end
            if (fetchTook) void'(src.pop_front());
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
